// File: rtl/mgmt_io_bank.sv
// mgmt_io_bank: Wishbone-mapped bank of bidirectional management GPIO pads with input synchroniser, optional glitch filter (IO_BANK_FILTER_EN) and edge interrupts
module mgmt_io_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic             wb_ack_o,
  output logic [31:0]      wb_dat_o,
  inout  wire  [WIDTH-1:0] pad_io,
  output logic [WIDTH-1:0] pad_oeb_o,
  output logic             irq_o
);
  logic [WIDTH-1:0] data_out, oeb, rise_en, fall_en, irq_status;
  logic [WIDTH-1:0] filt, filt_d, sync, rise, fall, clr, wmask, wdat;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [31:0]      bmask, rdata;
  logic [2:0]       idx;
  logic             req, wr, unused_bits;

  assign idx       = wb_adr_i[4:2];
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr        = req & wb_we_i;
  assign bmask     = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wmask     = bmask[WIDTH-1:0];
  assign wdat      = wb_dat_i[WIDTH-1:0] & wmask;
  assign sync      = sync_q[SYNC_STAGES-1];
  assign rise      = filt & ~filt_d & rise_en;
  assign fall      = ~filt & filt_d & fall_en;
  assign clr       = (wr && idx == 3'd5) ? wdat : '0;
  assign pad_oeb_o = oeb;
  assign irq_o     = |(irq_status & (rise_en | fall_en));
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, bmask, 8'(FILT_LEN)};

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign pad_io[i] = oeb[i] ? 1'bz : data_out[i];
  end

  // read mux, sampled into wb_dat_o on the edge that raises ack
  always_comb
    rdata = idx == 3'd0 ? 32'(data_out) :
            idx == 3'd1 ? 32'(oeb) :
            idx == 3'd2 ? 32'(filt) :
            idx == 3'd3 ? 32'(rise_en) :
            idx == 3'd4 ? 32'(fall_en) :
            idx == 3'd5 ? 32'(irq_status) : 32'd0;

  // pad input synchroniser chain
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pad_io;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end

`ifdef IO_BANK_FILTER_EN
  logic [7:0] cnt [WIDTH];

  // per-pin glitch filter: follow sync only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      filt <= '0;
      for (int k = 0; k < WIDTH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < WIDTH; k++)
        if (sync[k] == filt[k]) cnt[k] <= '0;
        else if (cnt[k] == 8'(FILT_LEN - 1)) begin
          filt[k] <= sync[k];
          cnt[k]  <= '0;
        end else cnt[k] <= cnt[k] + 8'd1;
    end
`else
  // unfiltered build: filtered input simply follows the synchroniser
  always_ff @(posedge clk or posedge RST)
    if (RST) filt <= '0;
    else filt <= sync;
`endif

  // bus handshake, register writes and edge capture; a set beats a same-cycle clear
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      data_out   <= '0;
      oeb        <= '1;
      rise_en    <= '0;
      fall_en    <= '0;
      irq_status <= '0;
      filt_d     <= '0;
    end else begin
      wb_ack_o   <= req;
      filt_d     <= filt;
      irq_status <= (irq_status & ~clr) | rise | fall;
      if (req) wb_dat_o <= rdata;
      if (wr && idx == 3'd0) data_out <= (data_out & ~wmask) | wdat;
      if (wr && idx == 3'd1) oeb <= (oeb & ~wmask) | wdat;
      if (wr && idx == 3'd3) rise_en <= (rise_en & ~wmask) | wdat;
      if (wr && idx == 3'd4) fall_en <= (fall_en & ~wmask) | wdat;
    end
endmodule

// File: tb/tb_mgmt_io_bank.sv
// tb_mgmt_io_bank: directed and randomized checks of mgmt_io_bank against a sample-history reference model
`timescale 1ns/1ps
module tb_mgmt_io_bank;
  localparam int SS = 2;
`ifdef IO_BANK_FILTER_EN
  localparam int FL = 4;
`else
  localparam int FL = 1;
`endif
  localparam int LAT = SS + FL;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, irq_o;
  logic [7:0]  pad_oeb_o, ext_val;
  wire  [7:0]  pad_io;
  int          nchk = 0, nfail = 0;

  mgmt_io_bank #(.WIDTH(8), .SYNC_STAGES(SS), .FILT_LEN(4)) dut (
    .clk(clk), .RST(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .wb_dat_o(wb_dat_o), .pad_io(pad_io), .pad_oeb_o(pad_oeb_o), .irq_o(irq_o)
  );

  for (genvar g = 0; g < 8; g++) begin : g_ext
    assign pad_io[g] = pad_oeb_o[g] ? ext_val[g] : 1'bz;
  end

  always #5 clk = ~clk;

  logic [7:0] m_dout, m_oeb, m_rise, m_fall, m_stat, m_filt, m_filt_d;
  logic [31:0] m_rd;
  logic        m_ack, m_irq;
  logic [7:0]  pad_q [$];
  assign m_irq = |(m_stat & (m_rise | m_fall));

  always @(posedge clk) begin
    logic [7:0] s, hi, lo, set, clr, msk, wd;
    logic req;
    if (rst) begin
      m_dout = 0; m_oeb = 8'hFF; m_rise = 0; m_fall = 0; m_stat = 0;
      m_filt = 0; m_filt_d = 0; m_rd = 0; m_ack = 0;
      pad_q.delete();
      for (int j = 0; j < SS + FL; j++) pad_q.push_back(8'h00);
    end else begin
      pad_q.push_back((m_oeb & ext_val) | (~m_oeb & m_dout));
      hi = 8'hFF; lo = 8'hFF;
      for (int j = 0; j < FL; j++) begin
        s = pad_q[pad_q.size() - 1 - SS - j];
        hi &= s; lo &= ~s;
      end
      void'(pad_q.pop_front());
      set = (m_filt & ~m_filt_d & m_rise) | (~m_filt & m_filt_d & m_fall);
      req = wb_cyc_i && wb_stb_i && !m_ack;
      msk = {8{wb_sel_i[0]}};
      wd  = wb_dat_i[7:0] & msk;
      clr = 0;
      if (req) begin
        case (wb_adr_i[4:2])
          3'd0: m_rd = {24'd0, m_dout};
          3'd1: m_rd = {24'd0, m_oeb};
          3'd2: m_rd = {24'd0, m_filt};
          3'd3: m_rd = {24'd0, m_rise};
          3'd4: m_rd = {24'd0, m_fall};
          3'd5: m_rd = {24'd0, m_stat};
          default: m_rd = 0;
        endcase
        if (wb_we_i)
          case (wb_adr_i[4:2])
            3'd0: m_dout = (m_dout & ~msk) | wd;
            3'd1: m_oeb  = (m_oeb & ~msk) | wd;
            3'd3: m_rise = (m_rise & ~msk) | wd;
            3'd4: m_fall = (m_fall & ~msk) | wd;
            3'd5: clr = wd;
            default: ;
          endcase
      end
      m_stat   = (m_stat & ~clr) | set;
      m_filt_d = m_filt;
      m_filt   = (m_filt | hi) & ~lo;
      m_ack    = req;
    end
  end

  task automatic wb_xfer(input logic we, input logic [2:0] idx, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
    wb_adr_i = {27'd0, idx, 2'b00}; wb_dat_i = dat; wb_sel_i = sel;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wb_ack_o && lat < 8);
    rd = wb_dat_o;
    nchk++;
    if (!wb_ack_o) begin
      nfail++;
      $display("FAIL wb_ack_timeout idx=%0d: no ack after %0d cycles, required within 8", idx, lat);
    end
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    int lat;
    rst = 1;
    repeat (3) @(negedge clk);
    nchk += 4;
    if (wb_ack_o !== 1'b0) begin nfail++; $display("FAIL rst_ack: got %b want 0", wb_ack_o); end
    if (wb_dat_o !== 32'd0) begin nfail++; $display("FAIL rst_dat: got %h want 0", wb_dat_o); end
    if (irq_o !== 1'b0) begin nfail++; $display("FAIL rst_irq: got %b want 0", irq_o); end
    if (pad_oeb_o !== 8'hFF) begin nfail++; $display("FAIL rst_oeb: got %h want ff", pad_oeb_o); end
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wb_xfer(0, 3'(i), 0, 4'hF, rd, lat);
      nchk++;
      if (rd !== (i == 1 ? 32'hFF : 32'h0)) begin
        nfail++; $display("FAIL rst_read idx=%0d: got %h want %h", i, rd, i == 1 ? 32'hFF : 32'h0);
      end
    end
  endtask

  task automatic test_drive_loopback;
    logic [31:0] rd;
    int lat;
    ext_val = 8'h00;
    wb_xfer(1, 3'd1, 32'hF0, 4'hF, rd, lat);
    wb_xfer(1, 3'd0, 32'hA5, 4'hF, rd, lat);
    nchk += 2;
    if (pad_io[3:0] !== 4'h5) begin nfail++; $display("FAIL drive_pads: got %h want 5", pad_io[3:0]); end
    if (pad_oeb_o !== 8'hF0) begin nfail++; $display("FAIL drive_oeb: got %h want f0", pad_oeb_o); end
    repeat (LAT - 1) @(negedge clk);
    wb_xfer(0, 3'd2, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h00) begin nfail++; $display("FAIL loopback_early: got %h want 0", rd); end
    wb_xfer(0, 3'd2, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h05) begin nfail++; $display("FAIL loopback: got %h want 05", rd); end
  endtask

  task automatic test_byte_enables;
    logic [31:0] rd;
    int lat;
    wb_xfer(1, 3'd0, 32'h0, 4'hF, rd, lat);
    wb_xfer(1, 3'd0, 32'hFFFFFFFF, 4'b0010, rd, lat);
    wb_xfer(0, 3'd0, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h00) begin nfail++; $display("FAIL sel_byte1: got %h want 0", rd); end
    wb_xfer(1, 3'd0, 32'hFFFFFFFF, 4'b0001, rd, lat);
    wb_xfer(0, 3'd0, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'hFF) begin nfail++; $display("FAIL sel_byte0: got %h want ff", rd); end
    wb_xfer(1, 3'd1, 32'h0, 4'b1110, rd, lat);
    wb_xfer(0, 3'd1, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'hF0) begin nfail++; $display("FAIL sel_oeb: got %h want f0", rd); end
    wb_xfer(1, 3'd6, 32'hFF, 4'hF, rd, lat);
    wb_xfer(0, 3'd6, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h00) begin nfail++; $display("FAIL idx6: got %h want 0", rd); end
    wb_xfer(1, 3'd1, 32'hFF, 4'hF, rd, lat);
    wb_xfer(1, 3'd0, 32'h0, 4'hF, rd, lat);
  endtask

  task automatic test_glitch;
    logic [31:0] rd;
    int lat, first;
    ext_val = 8'h00;
    wb_xfer(1, 3'd3, 32'h04, 4'hF, rd, lat);
    wb_xfer(1, 3'd4, 32'h00, 4'hF, rd, lat);
    repeat (LAT + 2) @(negedge clk);
    wb_xfer(1, 3'd5, 32'hFF, 4'hF, rd, lat);
    ext_val[2] = 1'b1;
    repeat (FL > 1 ? FL - 1 : 1) @(negedge clk);
    ext_val[2] = 1'b0;
    repeat (LAT + 3) begin
      @(negedge clk);
      nchk++;
      if (irq_o !== m_irq) begin nfail++; $display("FAIL glitch_irq: got %b want %b", irq_o, m_irq); end
    end
    wb_xfer(0, 3'd5, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== (FL > 1 ? 32'h0 : 32'h4)) begin nfail++; $display("FAIL glitch_status: got %h want %h", rd, FL > 1 ? 32'h0 : 32'h4); end
    wb_xfer(0, 3'd2, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h0) begin nfail++; $display("FAIL glitch_data_in: got %h want 0", rd); end
    wb_xfer(1, 3'd5, 32'hFF, 4'hF, rd, lat);
    ext_val[2] = 1'b1;
    first = 0;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      if (irq_o && first == 0) first = c;
    end
    nchk++;
    if (first != LAT + 1) begin nfail++; $display("FAIL stable_latency: irq at cycle %0d want %0d", first, LAT + 1); end
    wb_xfer(0, 3'd2, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h04) begin nfail++; $display("FAIL stable_data_in: got %h want 04", rd); end
    ext_val[2] = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    wb_xfer(1, 3'd3, 32'h00, 4'hF, rd, lat);
    wb_xfer(1, 3'd5, 32'hFF, 4'hF, rd, lat);
  endtask

  task automatic test_edge_irq_race;
    logic [31:0] rd;
    int lat, first;
    wb_xfer(1, 3'd3, 32'h01, 4'hF, rd, lat);
    wb_xfer(1, 3'd4, 32'h01, 4'hF, rd, lat);
    wb_xfer(1, 3'd5, 32'hFF, 4'hF, rd, lat);
    ext_val[0] = 1'b1;
    first = 0;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      nchk++;
      if (irq_o !== m_irq) begin nfail++; $display("FAIL edge_irq_cycle%0d: got %b want %b", c, irq_o, m_irq); end
      if (irq_o && first == 0) first = c;
    end
    nchk++;
    if (first != LAT + 1) begin nfail++; $display("FAIL edge_latency: irq at cycle %0d want %0d", first, LAT + 1); end
    wb_xfer(0, 3'd5, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h01) begin nfail++; $display("FAIL edge_status: got %h want 01", rd); end
    ext_val[0] = 1'b0;
    repeat (LAT) @(negedge clk);
    wb_xfer(1, 3'd5, 32'h01, 4'hF, rd, lat);
    wb_xfer(0, 3'd5, 0, 4'hF, rd, lat);
    nchk += 2;
    if (rd !== 32'h01) begin nfail++; $display("FAIL race_set_wins: got %h want 01", rd); end
    if (irq_o !== 1'b1) begin nfail++; $display("FAIL race_irq: got %b want 1", irq_o); end
    wb_xfer(1, 3'd5, 32'h01, 4'hF, rd, lat);
    wb_xfer(0, 3'd5, 0, 4'hF, rd, lat);
    nchk += 2;
    if (rd !== 32'h00) begin nfail++; $display("FAIL w1c_clear: got %h want 0", rd); end
    if (irq_o !== 1'b0) begin nfail++; $display("FAIL w1c_irq: got %b want 0", irq_o); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int lat;
    wb_xfer(1, 3'd0, 32'h3C, 4'hF, rd, lat);
    wb_xfer(1, 3'd3, 32'hFF, 4'hF, rd, lat);
    ext_val = 8'h00;
    repeat (LAT + 2) @(negedge clk);
    ext_val[1] = 1'b1;
    repeat (4) @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h0; rst = 1;
    repeat (3) begin
      @(negedge clk);
      nchk += 3;
      if (wb_ack_o !== 1'b0) begin nfail++; $display("FAIL midrst_ack: got %b want 0", wb_ack_o); end
      if (pad_oeb_o !== 8'hFF) begin nfail++; $display("FAIL midrst_oeb: got %h want ff", pad_oeb_o); end
      if (wb_dat_o !== 32'h0) begin nfail++; $display("FAIL midrst_dat: got %h want 0", wb_dat_o); end
    end
    wb_cyc_i = 0; wb_stb_i = 0; rst = 0;
    wb_xfer(0, 3'd1, 0, 4'hF, rd, lat);
    nchk += 2;
    if (lat != 1) begin nfail++; $display("FAIL midrst_first_ack: latency %0d want 1", lat); end
    if (rd !== 32'hFF) begin nfail++; $display("FAIL midrst_oeb_read: got %h want ff", rd); end
    repeat (LAT - 2) @(negedge clk);
    wb_xfer(0, 3'd2, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h00) begin nfail++; $display("FAIL midrst_filter_early: got %h want 0", rd); end
    wb_xfer(0, 3'd2, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h02) begin nfail++; $display("FAIL midrst_filter_done: got %h want 02", rd); end
    wb_xfer(0, 3'd0, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h00) begin nfail++; $display("FAIL midrst_dout: got %h want 0", rd); end
    wb_xfer(0, 3'd3, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h00) begin nfail++; $display("FAIL midrst_rise_en: got %h want 0", rd); end
    wb_xfer(0, 3'd5, 0, 4'hF, rd, lat);
    nchk++;
    if (rd !== 32'h00) begin nfail++; $display("FAIL midrst_status: got %h want 0", rd); end
  endtask

  task automatic test_random;
    logic busy, we;
    int wait_c;
    busy = 0; we = 0; wait_c = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      nchk += 4;
      if (wb_ack_o !== m_ack) begin nfail++; $display("FAIL rnd_ack n=%0d: got %b want %b", n, wb_ack_o, m_ack); end
      if (irq_o !== m_irq) begin nfail++; $display("FAIL rnd_irq n=%0d: got %b want %b", n, irq_o, m_irq); end
      if (pad_oeb_o !== m_oeb) begin nfail++; $display("FAIL rnd_oeb n=%0d: got %h want %h", n, pad_oeb_o, m_oeb); end
      if (pad_io !== ((m_oeb & ext_val) | (~m_oeb & m_dout))) begin
        nfail++; $display("FAIL rnd_pads n=%0d: got %h want %h", n, pad_io, (m_oeb & ext_val) | (~m_oeb & m_dout));
      end
      if (busy) begin
        if (wb_ack_o) begin
          if (!we) begin
            nchk++;
            if (wb_dat_o !== m_rd) begin nfail++; $display("FAIL rnd_read n=%0d idx=%0d: got %h want %h", n, wb_adr_i[4:2], wb_dat_o, m_rd); end
          end
          busy = 0; wb_cyc_i = 0; wb_stb_i = 0;
        end else if (++wait_c > 4) begin
          nchk++; nfail++;
          $display("FAIL rnd_ack_timeout n=%0d: no ack in %0d cycles", n, wait_c);
          busy = 0; wb_cyc_i = 0; wb_stb_i = 0;
        end
      end
      if ($urandom_range(3) == 0) ext_val = 8'($urandom);
      if (!busy && $urandom_range(2) == 0) begin
        we = 1'($urandom); busy = 1; wait_c = 0;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
        wb_adr_i = $urandom; wb_dat_i = $urandom; wb_sel_i = 4'($urandom);
      end
    end
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  initial begin
    rst = 1; ext_val = 8'h00;
    wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0; wb_we_i = 0; wb_cyc_i = 0; wb_stb_i = 0;
    test_reset;
    test_drive_loopback;
    test_byte_enables;
    test_glitch;
    test_edge_irq_race;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/mgmt_io_bank.md
# mgmt_io_bank

Parametrised bank of WIDTH bidirectional management GPIO pads behind a Wishbone slave port. It is the successor to the single-pin tristate buffer in the management SoC wrapper and adds the following per pin:
- output and direction registers;
- an input synchroniser;
- an optional glitch filter;
- rising/falling edge capture with a level interrupt to the core.

It sits between the management core's housekeeping Wishbone bus and the chip-level pads.

## Interface
Parameters:
- WIDTH, 8: number of pads, 1..32.
- SYNC_STAGES, 2: input synchroniser depth, 2..3.
- FILT_LEN, 4: consecutive stable cycles required before the filtered input changes, 2..255.

Ports:
- clk  input  1  single clock, all state on its rising edge.
- RST  input  1  reset, asynchronous, active-high.
- wb_adr_i  input  32  byte address; only bits [4:2] are decoded.
- wb_dat_i  input  32  write data.
- wb_sel_i  input  4  byte enables for writes.
- wb_we_i  input  1  write strobe.
- wb_cyc_i  input  1  bus cycle.
- wb_stb_i  input  1  strobe.
- wb_ack_o  output  1  acknowledge.
- wb_dat_o  output  32  read data.
- pad_io  inout  WIDTH  pads; driven from DATA_OUT when the OEB bit is 0, otherwise high-Z.
- pad_oeb_o  output  WIDTH  copy of the OEB register, for pad-cell control.
- irq_o  output  1  OR of (IRQ_STATUS & (RISE_EN | FALL_EN) per pin), from registers.

## Operation
- Register map (word index = wb_adr_i[4:2]):
  - 0 DATA_OUT (rw)
  - 1 OEB (rw; 1 = input)
  - 2 DATA_IN (ro, filtered value)
  - 3 RISE_EN (rw)
  - 4 FALL_EN (rw)
  - 5 IRQ_STATUS (read, write-1-to-clear)
  - 6 and 7 read 0; writes to them are ignored.
- Register width rules: bits at or above WIDTH read 0 and ignore writes. Writes honour wb_sel_i per byte.
- Input path:
  - pad_io passes through a SYNC_STAGES flop chain to give sync[i].
  - A per-pin counter cnt[i] (8 bits) drives filt[i].
  - If sync[i] == filt[i]: cnt <= 0.
  - Else if cnt == FILT_LEN-1: filt <= sync and cnt <= 0.
  - Else: cnt <= cnt+1.
- Edge capture:
  - filt_d is filt delayed by one cycle.
  - A rise (filt & ~filt_d) sets IRQ_STATUS[i] if RISE_EN[i].
  - A fall (~filt & filt_d) sets IRQ_STATUS[i] if FALL_EN[i].
  - Status bits are set only when the matching enable is 1; disabled edges are not latched.
- IRQ_STATUS clearing: a write of 1 clears the bit. If a set and a clear hit the same bit in the same cycle, the set wins.
- Output path: pads driven as an OEB=0 bit drive DATA_OUT. The input path still samples them, so DATA_IN reflects driven pads (loopback).
- Reset values: every output and register returns to a fixed value while RST is high.
  - DATA_OUT = 0, OEB = all ones (all pads high-Z), RISE_EN = FALL_EN = 0, IRQ_STATUS = 0.
  - Synchroniser flops, filt, filt_d and cnt = 0.
  - wb_ack_o = 0, wb_dat_o = 0, irq_o = 0.
  - Asserting RST mid-transaction aborts it. The next transaction after release is serviced normally.

## Timing
- Wishbone handshake:
  - wb_ack_o is registered. It asserts one cycle after the first cycle with wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - It is a single-cycle pulse, so continuous strobing gives an ack on every other cycle.
- Writes take effect on the ack edge. pad_io and pad_oeb_o change in the cycle wb_ack_o is high.
- Read data:
  - wb_dat_o is registered and valid while wb_ack_o is high.
  - It holds its last value otherwise (0 after reset).
  - DATA_IN is sampled at the edge that raises ack.
- Input latency: a pad change that stays stable reaches DATA_IN SYNC_STAGES+FILT_LEN cycles after the first sampling edge. With defaults this is 6 cycles.
- Glitch rejection: a pulse shorter than FILT_LEN cycles at the sync output never reaches filt.
- Edge-to-interrupt timing: IRQ_STATUS sets, and irq_o rises, one cycle after filt changes.
- irq_o is combinational from registers only, so it is glitch-free relative to clk.

## Configuration
- IO_BANK_FILTER_EN defined:
  - The glitch filter and cnt counters are compiled in as described above.
- IO_BANK_FILTER_EN undefined:
  - The counters are not built and filt <= sync every cycle.
  - Input latency becomes SYNC_STAGES+1 cycles.
  - Pulses of 1 cycle or longer at the sync output are captured.
  - FILT_LEN is ignored.

## Test plan
Benches use WIDTH=8, SYNC_STAGES=2, FILT_LEN=4 unless stated.
- Reset defaults:
  - Stimulus: assert RST, release, then read indices 0..7.
  - Expected reads: 0x00000000 except OEB, which reads 0x000000FF.
  - Expected outputs: pad_io all Z, irq_o = 0.
- Drive and loopback:
  - Stimulus: write OEB=0xF0 and DATA_OUT=0xA5.
  - Expected: pad_io[3:0] = 4'h5 on the ack cycle and pad_io[7:4] = Z. After 6 cycles, a DATA_IN read returns 0x05 with external pull-downs on [7:4].
- Byte enables:
  - Stimulus: write 0xFFFFFFFF to DATA_OUT with wb_sel_i=4'b0010.
  - Expected: DATA_OUT reads 0x00 (byte 1 lies above WIDTH=8).
  - Stimulus: repeat with sel=4'b0001.
  - Expected: DATA_OUT reads 0xFF.
- Glitch filter (FILTER_EN defined):
  - Stimulus: drive pad[2] high for 3 cycles, then low.
  - Expected: DATA_IN stays 0x00 and IRQ_STATUS stays 0.
  - Stimulus: hold pad[2] high for 10 cycles.
  - Expected: DATA_IN bit 2 = 1 six cycles after the first edge.
- Edge interrupt and W1C race:
  - Stimulus: RISE_EN=0x01, FALL_EN=0x01; toggle pad[0] 0→1.
  - Expected: IRQ_STATUS=0x01 and irq_o=1 seven cycles after the edge.
  - Stimulus: write IRQ_STATUS=0x01 in the same cycle a falling edge on pad[0] sets the bit.
  - Expected: the bit stays 1. A second W1C clears it and irq_o=0.
- Reset mid-operation:
  - Stimulus: assert RST while wb_stb_i is high and pad[1] is mid-filter with cnt=2.
  - Expected: wb_ack_o never pulses and all registers return to reset values.
  - Expected after release: the first transaction acks one cycle after its strobe, and pad[1] needs a full 6 cycles to reach DATA_IN.
